// File: rtl/membus_arbiter_pkg.sv
// rtl/membus_arbiter_pkg.sv - shared widths and helpers for the memory bus arbiter
package membus_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 18;
    localparam int DEF_DATA_WIDTH = 32;

    // Never returns less than 1 so single-entry indices still get a real bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/membus_arbiter_if.sv
// rtl/membus_arbiter_if.sv - master-side request bus and slave-side access bus
interface membus_arbiter_if
    import membus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
);
    logic [NUM_MASTERS-1:0]              m_strobe;
    logic [NUM_MASTERS-1:0]              m_write;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wrdata;
    logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_bytesel;
    logic [NUM_MASTERS-1:0]              m_ack;
    logic [DATA_WIDTH-1:0]               m_rddata;
    logic                                s_strobe;
    logic                                s_write;
    logic [ADDR_WIDTH-1:0]               s_addr;
    logic [DATA_WIDTH-1:0]               s_wrdata;
    logic [DATA_WIDTH/8-1:0]             s_bytesel;
    logic [DATA_WIDTH-1:0]               s_rddata;
    logic [clog2(NUM_MASTERS)-1:0]       grant_idx;

    // The arbiter is the slave of the requesting masters.
    modport slave (
        input  m_strobe, m_write, m_addr, m_wrdata, m_bytesel, s_rddata,
        output m_ack, m_rddata, s_strobe, s_write, s_addr, s_wrdata, s_bytesel, grant_idx
    );

    modport master (
        output m_strobe, m_write, m_addr, m_wrdata, m_bytesel, s_rddata,
        input  m_ack, m_rddata, s_strobe, s_write, s_addr, s_wrdata, s_bytesel, grant_idx
    );

endinterface

// File: rtl/membus_arbiter_rr_picker.sv
// rtl/membus_arbiter_rr_picker.sv - rotate-priority pick among non-host masters 1..N-1
module rr_picker
    import membus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int IDX_WIDTH   = clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:1] i_req,
    input  logic [IDX_WIDTH-1:0]   i_ptr,
    output logic                   o_valid,
    output logic [IDX_WIDTH-1:0]   o_idx
);

    // Lowest requester overall is the wrap-around fallback; lowest at/after the pointer overrides it.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int j = NUM_MASTERS - 1; j >= 1; j--) begin
            if (i_req[j]) begin
                o_valid = 1'b1;
                o_idx   = IDX_WIDTH'(j);
            end
        end
        for (int j = NUM_MASTERS - 1; j >= 1; j--) begin
            if (i_req[j] && (j >= int'(i_ptr))) begin
                o_idx = IDX_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - N-master memory bus arbiter: host priority, RR/fixed, starvation override
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS  = 3,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int RR_MODE      = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    membus_arbiter_if.slave    bus
);

    localparam int IW = clog2(NUM_MASTERS);
    localparam int CW = clog2(STARVE_LIMIT + 1);
    localparam int BW = DATA_WIDTH / 8;

    logic [IW-1:0]          r_ptr;
    logic [IW-1:0]          r_grant_idx;
    logic [NUM_MASTERS-1:0] r_ack;
    logic [CW-1:0]          r_cnt [1:NUM_MASTERS-1];

    logic                   w_rr_valid;
    logic [IW-1:0]          w_rr_idx;
    logic                   w_fp_valid;
    logic [IW-1:0]          w_fp_idx;
    logic                   w_starve_any;
    logic [IW-1:0]          w_starve_idx;
    logic                   w_valid;
    logic [IW-1:0]          w_win;
    logic [NUM_MASTERS-1:0] w_grant;

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_WIDTH   (IW)
    ) u_rr_picker (
        .i_req   (bus.m_strobe[NUM_MASTERS-1:1]),
        .i_ptr   (r_ptr),
        .o_valid (w_rr_valid),
        .o_idx   (w_rr_idx)
    );

    always_comb begin
        w_fp_valid   = 1'b0;
        w_fp_idx     = '0;
        w_starve_any = 1'b0;
        w_starve_idx = '0;
        for (int j = NUM_MASTERS - 1; j >= 1; j--) begin
            if (bus.m_strobe[j]) begin
                w_fp_valid = 1'b1;
                w_fp_idx   = IW'(j);
            end
            if ((STARVE_LIMIT != 0) && bus.m_strobe[j] && (r_cnt[j] == CW'(STARVE_LIMIT))) begin
                w_starve_any = 1'b1;
                w_starve_idx = IW'(j);
            end
        end
    end

    // Starvation only lifts a master above the host; among non-hosts the normal policy still rules.
    always_comb begin
        w_valid = 1'b0;
        w_win   = '0;
        if (rst_n) begin
            if (bus.m_strobe[0]) begin
                w_valid = 1'b1;
                w_win   = w_starve_any ? w_starve_idx : '0;
            end else if (RR_MODE != 0) begin
                w_valid = w_rr_valid;
                w_win   = w_rr_idx;
            end else begin
                w_valid = w_fp_valid;
                w_win   = w_fp_idx;
            end
        end
    end

    always_comb begin
        w_grant       = '0;
        bus.s_strobe  = w_valid;
        bus.s_write   = 1'b0;
        bus.s_addr    = '0;
        bus.s_wrdata  = '0;
        bus.s_bytesel = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (w_valid && (w_win == IW'(j))) begin
                w_grant[j]    = 1'b1;
                bus.s_write   = bus.m_write[j];
                bus.s_addr    = bus.m_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                bus.s_wrdata  = bus.m_wrdata[j*DATA_WIDTH +: DATA_WIDTH];
                bus.s_bytesel = bus.m_bytesel[j*BW +: BW];
            end
        end
    end

    assign bus.m_ack     = r_ack;
    assign bus.m_rddata  = bus.s_rddata;
    assign bus.grant_idx = r_grant_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack       <= '0;
            r_grant_idx <= '0;
            r_ptr       <= IW'(1);
            for (int j = 1; j < NUM_MASTERS; j++) begin
                r_cnt[j] <= '0;
            end
        end else begin
            r_ack <= w_grant;
            if (w_valid) begin
                r_grant_idx <= w_win;
            end
            if ((RR_MODE != 0) && w_valid && (w_win != '0)) begin
                r_ptr <= (w_win == IW'(NUM_MASTERS - 1)) ? IW'(1) : w_win + IW'(1);
            end
            for (int j = 1; j < NUM_MASTERS; j++) begin
                if (!bus.m_strobe[j] || w_grant[j]) begin
                    r_cnt[j] <= '0;
                end else if (r_cnt[j] != CW'(STARVE_LIMIT)) begin
                    r_cnt[j] <= r_cnt[j] + CW'(1);
                end
            end
        end
    end

endmodule
